// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable first-word-fall-through read.
module sync_fifo_flags #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned D_WIDTH   = 8,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 2,
    parameter bit          FWFT      = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [D_WIDTH-1:0]       wr_data,
    input  logic                     rd_en,
    output logic [D_WIDTH-1:0]       rd_data,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    input  logic                     clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] AfThresh = PW'(AF_THRESH);
    localparam logic [PW-1:0] AeThresh = PW'(AE_THRESH);

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic [AW-1:0]      wr_addr, rd_addr;
    logic               full, empty, wr_ok, rd_ok;

    always_comb begin
        wr_addr = wr_ptr_q[AW-1:0];
        rd_addr = rd_ptr_q[AW-1:0];
        empty   = (wr_ptr_q == rd_ptr_q);
        // Same slot with differing wrap bits means the writer is a full lap ahead.
        full    = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        wr_ok   = wr_en & ~full;
        rd_ok   = rd_en & ~empty;

        wr_ptr_d    = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
        rd_data_d   = rd_ok ? mem_q[rd_addr] : rd_data_q;
        // Set wins over clear when both happen in the same cycle.
        overflow_d  = (wr_en & full) | (overflow_q & ~clr_err);
        underflow_d = (rd_en & empty) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        count_o        = wr_ptr_q - rd_ptr_q;
        full_o         = full;
        empty_o        = empty;
        almost_full_o  = (count_o >= AfThresh);
        almost_empty_o = (count_o <= AeThresh);
        overflow_o     = overflow_q;
        underflow_o    = underflow_q;
        rd_data        = FWFT ? mem_q[rd_addr] : rd_data_q;
    end

endmodule
